dbus_bridge: RTL and testbench

//  Data-side bus bridge directly downstream of the single-cycle RV32I core's data port.

---
 rtl/dbus_pkg.sv | 52 +++++
 rtl/dbus_wbuf.sv | 61 ++++++
 rtl/dbus_bridge.sv | 153 +++++++++++++++
 tb/tb_dbus_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared encodings, types and lane helpers for the data-bus bridge
package dbus_pkg;

    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wb_entry_t;

    // dsize 11 is never legal; halves need an even address, words a word boundary
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            DS_BYTE: is_aligned = 1'b1;
            DS_HALF: is_aligned = ~a[0];
            DS_WORD: is_aligned = (a == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            DS_BYTE: lane_be = 4'b0001 << a;
            DS_HALF: lane_be = 4'b0011 << a;
            DS_WORD: lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    // Right-justify the addressed lanes and clear everything above the access width
    function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] a);
        logic [31:0] sh;
        sh = rdata >> {a, 3'b000};
        case (size)
            DS_BYTE: load_align = {24'h0, sh[7:0]};
            DS_HALF: load_align = {16'h0, sh[15:0]};
            default: load_align = sh;
        endcase
    endfunction

endpackage

// File: rtl/dbus_wbuf.sv
// rtl/dbus_wbuf.sv - posted-store FIFO with extra-MSB pointers
module dbus_wbuf
    import dbus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    wb_entry_t   mem_q [DEPTH];
    wb_entry_t   mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this edge, so a push into a full buffer can land in it
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Next storage contents and pointers
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Storage and pointer registers; reset discards any buffered stores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - core data port to word-wide acked memory bus with posted stores
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int          WB_DEPTH = 4,
    parameter logic [31:0] RST_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [1:0]  dsize,
    inout  wire  [31:0] ddata,
    output logic        dready_n,
    output logic        dbusy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        misalign,
    output logic [31:0] err_addr
);
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_q, load_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        misalign_q, misalign_d;

    logic        wb_full, wb_empty, wb_push, wb_pop;
    wb_entry_t   wb_head, wb_in;
    logic [1:0]  lane;
    logic        aligned, load_req, store_acc, mis_load;

    assign lane      = daddr[1:0];
    assign aligned   = is_aligned(dsize, lane);
    assign load_req  = dreq & ~dwrite;
    assign store_acc = dreq & dwrite & ~wb_full;
    // Misaligned stores are still accepted so the core moves on; they just never reach memory
    assign wb_push   = store_acc & aligned;
    assign wb_pop    = (state_q == ST_WR) & mem_ack;
    assign mis_load  = (state_q == ST_IDLE) & wb_empty & load_req & ~aligned;
    assign wb_in     = '{addr: daddr[31:2], be: lane_be(dsize, lane), data: ddata << {lane, 3'b000}};

    dbus_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .push_data (wb_in),
        .pop       (wb_pop),
        .head      (wb_head),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    assign dbusy     = wb_full;
    assign ddata     = load_req ? load_q : 32'bz;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign misalign  = misalign_q;
    assign err_addr  = err_addr_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: drain posted stores before any load so loads never overtake them
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!wb_empty) begin
                    state_d = ST_WR;
                end else if (load_req) begin
                    state_d = aligned ? ST_RD : ST_RESP;
                end
            end
            ST_WR:   if (mem_ack) state_d = ST_IDLE;
            ST_RD:   if (mem_ack) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: bus fields are loaded on entry to WR/RD and held until the ack
    always_comb begin
        dready_n    = (state_q != ST_RESP);
        mem_req_d   = (state_d == ST_WR) || (state_d == ST_RD);
        mem_we_d    = (state_d == ST_WR);
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        load_d      = load_q;
        misalign_d  = 1'b0;
        err_addr_d  = err_addr_q;
        if (state_q == ST_IDLE && state_d == ST_WR) begin
            mem_addr_d  = wb_head.addr;
            mem_be_d    = wb_head.be;
            mem_wdata_d = wb_head.data;
        end else if (state_q == ST_IDLE && state_d == ST_RD) begin
            mem_addr_d = daddr[31:2];
            mem_be_d   = lane_be(dsize, lane);
        end
        if (state_q == ST_RD && mem_ack) begin
            load_d = load_align(mem_rdata, dsize, lane);
        end else if (mis_load) begin
            load_d = 32'h0;
        end
        if (mis_load || (store_acc && !aligned)) begin
            misalign_d = 1'b1;
            err_addr_d = daddr;
        end
    end

    // Registered bus outputs, load data and error capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_q      <= RST_DATA;
            misalign_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_q      <= load_d;
            misalign_q  <= misalign_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - directed scoreboard bench for dbus_bridge
module tb_dbus_bridge;
    import dbus_pkg::*;

    logic        clk, rst, dreq, dwrite;
    logic [31:0] daddr, st_data;
    logic [1:0]  dsize;
    wire  [31:0] ddata;
    logic        dready_n, dbusy, mem_req, mem_we, mem_ack, misalign;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata, err_addr;

    assign ddata = (dreq && dwrite) ? st_data : 32'bz;

    dbus_bridge #(.WB_DEPTH(4), .RST_DATA(32'h0)) dut (
        .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .daddr(daddr), .dsize(dsize),
        .ddata(ddata), .dready_n(dready_n), .dbusy(dbusy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .misalign(misalign), .err_addr(err_addr)
    );

    typedef struct {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] mem_model [logic [29:0]];
    int          total = 0, passed = 0;
    int          req_cycles = 0, mis_cnt = 0;
    logic        ack_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Memory responder: zero-wait ack when enabled, byte-merged model, write scoreboard
    initial begin : responder
        logic [31:0] w;
        wr_t         e;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (misalign) mis_cnt++;
            mem_ack = 1'b0;
            if (mem_req && ack_en && rst) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexp_wr", {2'b00, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", {2'b00, mem_addr}, {2'b00, e.a});
                        chk("wr_be", {28'h0, mem_be}, {28'h0, e.be});
                        chk("wr_data", mem_wdata, e.d);
                    end
                    w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    mem_model[mem_addr] = w;
                end else begin
                    chk("rd_after_wr", exp_wr.size(), 0);
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                            input bit exp_push, input logic [3:0] ebe, input logic [31:0] ewd,
                            output int waited);
        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b1; daddr = addr; dsize = size; st_data = data;
        if (exp_push) exp_wr.push_back('{addr[31:2], ebe, ewd});
        waited = 0;
        while (dbusy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 dreq = 1'b0; dwrite = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] exp, output int lat);
        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b0; daddr = addr; dsize = size;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (dready_n && lat < 60);
        chk({tag, "_ready"}, {31'h0, dready_n}, 0);
        chk({tag, "_data"}, ddata, exp);
        @(posedge clk);
        #1 dreq = 1'b0;
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'h0, dready_n}, 1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_wr.size() != 0; i++) @(negedge clk);
        chk(tag, exp_wr.size(), 0);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_dready_n"}, {31'h0, dready_n}, 1);
        chk({p, "_dbusy"}, {31'h0, dbusy}, 0);
        chk({p, "_mem_req"}, {31'h0, mem_req}, 0);
        chk({p, "_mem_we"}, {31'h0, mem_we}, 0);
        chk({p, "_mem_addr"}, {2'b00, mem_addr}, 0);
        chk({p, "_mem_be"}, {28'h0, mem_be}, 0);
        chk({p, "_mem_wdata"}, mem_wdata, 0);
        chk({p, "_misalign"}, {31'h0, misalign}, 0);
        chk({p, "_err_addr"}, err_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin : stim
        int w, w5, lat, r0, m0;
        rst = 1'b0; dreq = 1'b0; dwrite = 1'b0; daddr = 32'h0; dsize = DS_WORD; st_data = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b1;
        ack_en = 1'b1;

        do_store(32'h100, DS_WORD, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, w);
        chk("sw_nobusy", w, 0);
        drain("sw_drain");
        chk("sw_dbusy", {31'h0, dbusy}, 0);

        do_store(32'h103, DS_BYTE, 32'h000000AB, 1, 4'b1000, 32'hAB000000, w);
        drain("sb_drain");
        do_load("lbu", 32'h103, DS_BYTE, 32'h000000AB, lat);
        chk("lbu_latency", lat, 2);
        do_load("lhu", 32'h102, DS_HALF, 32'h0000ABAD, lat);
        do_load("lw100", 32'h100, DS_WORD, 32'hABADBEEF, lat);

        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h400 + 32'(4 * i), DS_WORD, 32'(i + 1), 1, 4'b1111, 32'(i + 1), w);
            chk("burst_nobusy", w, 0);
        end
        fork
            do_store(32'h410, DS_WORD, 32'h5, 1, 4'b1111, 32'h5, w5);
            begin
                repeat (4) @(negedge clk);
                chk("burst_full", {31'h0, dbusy}, 1);
                chk("burst_hold_req", {31'h0, mem_req}, 1);
                chk("burst_hold_addr", {2'b00, mem_addr}, 32'h100);
                ack_en = 1'b1;
            end
        join
        chk("burst_stalled", {31'h0, (w5 > 0)}, 1);
        drain("burst_drain");
        do_load("lw410", 32'h410, DS_WORD, 32'h5, lat);

        do_store(32'h200, DS_WORD, 32'h11, 1, 4'b1111, 32'h11, w);
        do_load("lw200", 32'h200, DS_WORD, 32'h11, lat);

        r0 = req_cycles; m0 = mis_cnt;
        do_load("lh_mis", 32'h101, DS_HALF, 32'h0, lat);
        chk("lh_mis_noreq", req_cycles - r0, 0);
        chk("lh_mis_pulse", mis_cnt - m0, 1);
        chk("lh_mis_err", err_addr, 32'h101);

        m0 = mis_cnt;
        do_store(32'h203, DS_HALF, 32'h7777, 0, 4'b0000, 32'h0, w);
        repeat (4) @(negedge clk);
        chk("sh_mis_pulse", mis_cnt - m0, 1);
        chk("sh_mis_err", err_addr, 32'h203);
        drain("sh_mis_nowr");

        ack_en = 1'b0;
        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h300; dsize = DS_WORD;
        repeat (2) @(negedge clk);
        chk("rd_pending_req", {31'h0, mem_req}, 1);
        chk("rd_pending_addr", {2'b00, mem_addr}, 32'hC0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        chk("midrst_ddata", ddata, 32'h0);
        dreq = 1'b0;
        rst = 1'b1;
        ack_en = 1'b1;
        r0 = req_cycles;
        repeat (4) @(negedge clk);
        chk("midrst_empty_noreq", req_cycles - r0, 0);
        do_load("post_rst_lw", 32'h200, DS_WORD, 32'h11, lat);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
